// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the signed calculator datapath.
package calc_pkg;

  localparam logic [1:0] SEL_MUL = 2'b01;
  localparam logic [1:0] SEL_DIV = 2'b10;

  localparam int DW = 8;
  localparam int VW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } div_state_t;

endpackage

// File: rtl/signed_seq_divider_div_step.sv
// One restoring shift-subtract iteration of the divider.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] r,
  input  logic          a_bit,
  input  logic [VW-1:0] b,
  output logic [VW-1:0] r_next,
  output logic          q_bit
);

  logic [VW:0] shifted;

  // Shift in the next dividend bit, subtract the divisor when it fits.
  // The restored remainder is always below b, so VW bits hold it.
  always_comb begin
    shifted = {r, a_bit};
    q_bit   = (shifted >= {1'b0, b});
    r_next  = q_bit ? VW'(shifted - {1'b0, b}) : shifted[VW-1:0];
  end

endmodule

// File: rtl/signed_seq_divider.sv
// Sequential sign-magnitude divider with Start/Busy/Done handshake.
module signed_seq_divider
  import calc_pkg::*;
#(
  parameter int DW = calc_pkg::DW,
  parameter int VW = calc_pkg::VW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [1:0]    sel,
  input  logic [DW-1:0] A,
  input  logic          s0,
  input  logic [VW-1:0] B,
  input  logic          s1,
  output logic          Busy,
  output logic          Done,
  output logic          DivByZero,
  output logic [DW:0]   Quotient,
  output logic [VW:0]   Remainder
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  div_state_t    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] a_sh;
  logic [VW-1:0] b_r;
  logic          s0_r;
  logic          s1_r;
  logic [VW-1:0] r;
  logic [DW-1:0] q;

  logic [VW-1:0] r_next;
  logic          q_bit;
  logic [DW-1:0] q_next;
  logic          q_sign;
  logic          r_sign;

  div_step #(.VW(VW)) u_step (
    .r      (r),
    .a_bit  (a_sh[DW-1]),
    .b      (b_r),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  // Final quotient/remainder magnitudes and zero-suppressed signs.
  always_comb begin
    q_next = {q[DW-2:0], q_bit};
    q_sign = (s0_r ^ s1_r) & (|q_next);
    r_sign = s0_r & (|r_next);
  end

  // Control FSM and datapath registers. The last CALC edge registers
  // the results directly so Done appears in the FINISH cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      a_sh      <= '0;
      b_r       <= '0;
      s0_r      <= 1'b0;
      s1_r      <= 1'b0;
      r         <= '0;
      q         <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start && sel == SEL_DIV) begin
            a_sh <= A;
            b_r  <= B;
            s0_r <= s0;
            s1_r <= s1;
            r    <= '0;
            q    <= '0;
            cnt  <= '0;
            if (B != '0) begin
              state <= CALC;
              Busy  <= 1'b1;
            end else begin
              state     <= FINISH;
              Done      <= 1'b1;
              DivByZero <= 1'b1;
              Quotient  <= {1'b0, {DW{1'b1}}};
              Remainder <= '0;
            end
          end
        end
        CALC: begin
          r    <= r_next;
          q    <= q_next;
          a_sh <= a_sh << 1;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= FINISH;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            DivByZero <= 1'b0;
            Quotient  <= {q_sign, q_next};
            Remainder <= {r_sign, r_next};
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Self-checking bench for signed_seq_divider: vector table, corner
// sequences, and randomized operations against an arithmetic model.
module tb_signed_seq_divider;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [1:0] sel;
  logic [7:0] A;
  logic       s0;
  logic [3:0] B;
  logic       s1;
  logic       Busy;
  logic       Done;
  logic       DivByZero;
  logic [8:0] Quotient;
  logic [4:0] Remainder;

  int passed = 0;
  int total  = 0;

  signed_seq_divider #(.DW(8), .VW(4)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .sel       (sel),
    .A         (A),
    .s0        (s0),
    .B         (B),
    .s1        (s1),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .Quotient  (Quotient),
    .Remainder (Remainder)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] a;
    logic       sa;
    logic [3:0] b;
    logic       sb;
    logic [8:0] eq;
    logic [4:0] er;
    logic       ez;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Issue one operation and wait (bounded) for Done; returns Busy cycle count.
  task automatic run_op(input logic [7:0] a, input logic sa, input logic [3:0] b,
                        input logic sb, output int busy_cnt, output bit got_done);
    busy_cnt = 0;
    got_done = 0;
    @(negedge Clk);
    A = a; s0 = sa; B = b; s1 = sb; sel = 2'b10; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (Done) begin
        got_done = 1;
        break;
      end
      if (Busy) busy_cnt++;
    end
  endtask

  // Checks results in the Done cycle, then that Done drops after one cycle.
  task automatic check_op(input string tag, input int busy_cnt, input bit got_done,
                          input logic [8:0] eq, input logic [4:0] er, input logic ez);
    chk({tag, " done"}, int'(got_done), 1);
    chk({tag, " busycycles"}, busy_cnt, ez ? 0 : 8);
    chk({tag, " busy@done"}, int'(Busy), 0);
    chk({tag, " quotient"}, int'(Quotient), int'(eq));
    chk({tag, " remainder"}, int'(Remainder), int'(er));
    chk({tag, " divbyzero"}, int'(DivByZero), int'(ez));
    @(negedge Clk);
    chk({tag, " donepulse"}, int'(Done), 0);
  endtask

  // Arithmetic reference: truncating division in sign-magnitude form.
  function automatic void model(input int a, input bit sa, input int b, input bit sb,
                                output logic [8:0] eq, output logic [4:0] er, output logic ez);
    int qm, rm;
    bit qs, rs;
    if (b == 0) begin
      eq = 9'h0FF; er = 5'h00; ez = 1'b1;
    end else begin
      qm = a / b;
      rm = a % b;
      qs = (sa ^ sb) && (qm != 0);
      rs = sa && (rm != 0);
      eq = 9'((qs ? 256 : 0) + qm);
      er = 5'((rs ? 16 : 0) + rm);
      ez = 1'b0;
    end
  endfunction

  vec_t vecs[6];
  int   bc;
  bit   gd;
  int   seen_busy, seen_done;
  logic [8:0] mq;
  logic [4:0] mr;
  logic       mz;

  initial begin
    Reset = 1'b1; Start = 1'b0; sel = 2'b00; A = '0; s0 = 0; B = '0; s1 = 0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("reset busy", int'(Busy), 0);
    chk("reset done", int'(Done), 0);
    chk("reset dz", int'(DivByZero), 0);
    chk("reset q", int'(Quotient), 0);
    chk("reset r", int'(Remainder), 0);

    vecs[0] = '{8'd100, 1'b0, 4'd7, 1'b0, 9'h00E, 5'h02, 1'b0};
    vecs[1] = '{8'd100, 1'b1, 4'd7, 1'b0, 9'h10E, 5'h12, 1'b0};
    vecs[2] = '{8'd100, 1'b1, 4'd7, 1'b1, 9'h00E, 5'h12, 1'b0};
    vecs[3] = '{8'd3,   1'b1, 4'd9, 1'b0, 9'h000, 5'h13, 1'b0};
    vecs[4] = '{8'd255, 1'b0, 4'd1, 1'b0, 9'h0FF, 5'h00, 1'b0};
    vecs[5] = '{8'd5,   1'b0, 4'd0, 1'b0, 9'h0FF, 5'h00, 1'b1};
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].sa, vecs[i].b, vecs[i].sb, bc, gd);
      check_op($sformatf("vec%0d", i), bc, gd, vecs[i].eq, vecs[i].er, vecs[i].ez);
    end

    // Start re-pulsed mid-CALC with other operands must be ignored.
    @(negedge Clk);
    A = 8'd100; s0 = 0; B = 4'd7; s1 = 0; sel = 2'b10; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (3) @(negedge Clk);
    A = 8'd50; B = 4'd3; s0 = 1; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    gd = 0;
    for (int i = 0; i < 20; i++) begin
      if (Done) begin gd = 1; break; end
      @(negedge Clk);
    end
    check_op("midstart", 8, gd, 9'h00E, 5'h02, 1'b0);

    // Multiply opcode must not start the divider.
    @(negedge Clk);
    A = 8'd20; B = 4'd3; sel = 2'b01; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    seen_busy = 0; seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (Busy) seen_busy++;
      if (Done) seen_done++;
    end
    chk("selmul busy", seen_busy, 0);
    chk("selmul done", seen_done, 0);

    // Reset during the 4th CALC cycle aborts with cleared outputs.
    @(negedge Clk);
    A = 8'd200; s0 = 1; B = 4'd6; s1 = 0; sel = 2'b10; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort busy", int'(Busy), 0);
    chk("abort q", int'(Quotient), 0);
    chk("abort r", int'(Remainder), 0);
    chk("abort dz", int'(DivByZero), 0);
    seen_done = int'(Done);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Done) seen_done++;
    end
    chk("abort nodone", seen_done, 0);
    run_op(8'd200, 1'b1, 4'd6, 1'b0, bc, gd);
    check_op("after abort", bc, gd, 9'h121, 5'h12, 1'b0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra;
      logic [3:0] rb;
      logic       rsa, rsb;
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      rsa = 1'($urandom);
      rsb = 1'($urandom);
      model(int'(ra), rsa, int'(rb), rsb, mq, mr, mz);
      run_op(ra, rsa, rb, rsb, bc, gd);
      check_op($sformatf("rand%0d", i), bc, gd, mq, mr, mz);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
